// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Turns raw, bouncy, asynchronous push-button pins into clean debounced
//   levels and single-cycle press/release strobes. Each channel is handled
//   independently:
//     raw pin -> polarity normalisation -> 2-flop synchronizer
//             -> counter debouncer -> registered press/release edge strobes
//
// Ports:
//   clk            in   1         system clock, all state on the rising edge
//   sync_reset     in   1         synchronous, active-high reset
//   raw_in         in   CHANNELS  asynchronous raw button pins
//   level_out      out  CHANNELS  debounced level, 1 = pressed
//   press_pulse    out  CHANNELS  one-cycle strobe on debounced 0->1
//                                 (plus auto-repeat strobes when enabled)
//   release_pulse  out  CHANNELS  one-cycle strobe on debounced 1->0
//   any_level      out  1         OR of level_out
//
// Build option:
//   BUTTON_CONDITIONER_REPEAT_EN - when defined, a held button produces extra
//   press_pulse strobes REPEAT_DELAY cycles after the original press and then
//   every REPEAT_PERIOD cycles until released. When undefined, the REPEAT_*
//   parameters have no effect and each press yields exactly one strobe.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int   CHANNELS        = 4,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic ACTIVE_LOW      = 1'b1,
    parameter int   REPEAT_DELAY    = 25000000,
    parameter int   REPEAT_PERIOD   = 10000000
) (
    input  logic                clk,
    input  logic                sync_reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_level
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_conditioner: all size/timing parameters must be >= 1");
    end

    // Normalised input: 1 always means "pressed", whatever the board wiring.
    logic [CHANNELS-1:0] w_norm;
    assign w_norm = raw_in ^ {CHANNELS{ACTIVE_LOW}};

    // ---- stage: two-flop synchronizer ----
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_norm;
            r_sync2 <= r_sync1;
        end
    end

    // ---- stage: per-channel debouncer and edge strobes ----
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic             r_level;
        logic             r_press;
        logic             r_release;
        logic [CNT_W-1:0] r_db_cnt;
        logic             w_differs;
        logic             w_settled;
        logic             w_new_press;

        // The synchronized input disagrees with the debounced level; once it
        // has done so for DEBOUNCE_CYCLES consecutive samples the level flips.
        assign w_differs   = r_sync2[gi] != r_level;
        assign w_settled   = w_differs && (r_db_cnt == DB_LAST);
        assign w_new_press = w_settled && r_sync2[gi];

        always_ff @(posedge clk) begin
            if (sync_reset) begin
                r_level   <= 1'b0;
                r_release <= 1'b0;
                r_db_cnt  <= '0;
            end else begin
                // Strobe is registered on the same edge the level flips, so it
                // is high exactly in the first cycle the new level is visible.
                r_release <= w_settled && !r_sync2[gi];
                if (!w_differs) begin
                    // Any return to the current level discards a partial count.
                    r_db_cnt <= '0;
                end else if (w_settled) begin
                    r_level  <= r_sync2[gi];
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + CNT_W'(1);
                end
            end
        end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
        localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int REP_W   = $clog2(REP_MAX + 1);
        localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
        localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

        logic [REP_W-1:0] r_rep_cnt;
        logic             r_rep_periodic;   // 0: waiting for first repeat, 1: periodic
        logic             w_held;
        logic             w_rep_fire;

        // A channel whose level is about to drop this edge is no longer held,
        // so a release never coincides with a repeat strobe.
        assign w_held     = r_level && !w_settled;
        assign w_rep_fire = w_held &&
                            (r_rep_cnt == (r_rep_periodic ? PERIOD_LAST : DELAY_LAST));

        always_ff @(posedge clk) begin
            if (sync_reset) begin
                r_press        <= 1'b0;
                r_rep_cnt      <= '0;
                r_rep_periodic <= 1'b0;
            end else begin
                r_press <= w_new_press || w_rep_fire;
                if (w_held) begin
                    if (w_rep_fire) begin
                        r_rep_cnt      <= '0;
                        r_rep_periodic <= 1'b1;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + REP_W'(1);
                    end
                end else begin
                    // Covers the original press (count starts from the pulse)
                    // and release (count abandoned immediately).
                    r_rep_cnt      <= '0;
                    r_rep_periodic <= 1'b0;
                end
            end
        end
`else
        always_ff @(posedge clk) begin
            if (sync_reset) begin
                r_press <= 1'b0;
            end else begin
                r_press <= w_new_press;
            end
        end
`endif

        assign level_out[gi]     = r_level;
        assign press_pulse[gi]   = r_press;
        assign release_pulse[gi] = r_release;
    end

    assign any_level = |level_out;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner with CHANNELS=4, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=5. A reference model describes
// the debouncer as "flip once the last DB synchronized samples all disagree
// with the current level" and the repeat behaviour as arithmetic on the time
// elapsed since the press; every cycle the DUT outputs are compared with it.
// Directed scenarios add explicit timing and pulse-count checks.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic [CH-1:0] raw_in;
    logic [CH-1:0] level_out;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic          any_level;

    button_conditioner #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DB),
        .ACTIVE_LOW     (1'b1),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .raw_in       (raw_in),
        .level_out    (level_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .any_level    (any_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cnt_press   [CH];
    int cnt_release [CH];

    // Reference model state
    bit          m_s1    [CH];
    bit          m_s2    [CH];
    bit          m_level [CH];
    int          m_nobs  [CH];
    bit [DB-1:0] m_hist  [CH];
    int          m_t     [CH];
    logic [CH-1:0] e_press;
    logic [CH-1:0] e_release;
    logic [CH-1:0] e_level;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [CH-1:0] raw, input logic rst);
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_s1[c]      = 1'b0;
                m_s2[c]      = 1'b0;
                m_level[c]   = 1'b0;
                m_nobs[c]    = 0;
                m_hist[c]    = '0;
                m_t[c]       = 0;
                e_press[c]   = 1'b0;
                e_release[c] = 1'b0;
            end else begin
                bit flip;
                m_hist[c] = {m_hist[c][DB-2:0], m_s2[c]};
                if (m_nobs[c] < DB) m_nobs[c]++;
                flip = (m_nobs[c] == DB) && (m_hist[c] == {DB{~m_level[c]}});
                e_press[c]   = flip && !m_level[c];
                e_release[c] = flip && m_level[c];
`ifdef BUTTON_CONDITIONER_REPEAT_EN
                if (e_press[c]) begin
                    m_t[c] = 0;
                end else if (m_level[c] && !flip) begin
                    m_t[c]++;
                    if (m_t[c] >= RD && ((m_t[c] - RD) % RP) == 0) e_press[c] = 1'b1;
                end
`endif
                m_level[c] = m_level[c] ^ flip;
                m_s2[c]    = m_s1[c];
                m_s1[c]    = ~raw[c];
            end
            e_level[c] = m_level[c];
        end
    endtask

    // One clock: model consumes the inputs present at the edge, outputs are
    // compared 1 time unit later, away from the edge.
    task automatic step();
        @(posedge clk);
        model_edge(raw_in, sync_reset);
        #1;
        check_eq("level_out", 32'(level_out), 32'(e_level));
        check_eq("press_pulse", 32'(press_pulse), 32'(e_press));
        check_eq("release_pulse", 32'(release_pulse), 32'(e_release));
        check_eq("any_level", 32'(any_level), 32'(|e_level));
        for (int c = 0; c < CH; c++) begin
            cnt_press[c]   += int'(press_pulse[c]);
            cnt_release[c] += int'(release_pulse[c]);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) begin
            cnt_press[c]   = 0;
            cnt_release[c] = 0;
        end
    endtask

    initial begin
        int hold_pulses;
        sync_reset = 1'b1;
        raw_in     = 4'b1111;
        clear_counts();
        for (int c = 0; c < CH; c++) begin
            m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_level[c] = 1'b0;
            m_nobs[c] = 0; m_hist[c] = '0; m_t[c] = 0;
        end
        e_press = '0; e_release = '0; e_level = '0;

        // Reset, then idle with all buttons released
        steps(3);
        check_eq("reset_level", 32'(level_out), 32'h0);
        check_eq("reset_any", 32'(any_level), 32'h0);
        sync_reset = 1'b0;
        clear_counts();
        steps(20);
        check_eq("idle_no_press", 32'(cnt_press[0] + cnt_press[1] + cnt_press[2] + cnt_press[3]), 32'd0);
        check_eq("idle_no_release", 32'(cnt_release[0] + cnt_release[1] + cnt_release[2] + cnt_release[3]), 32'd0);

        // Clean press on channel 0: level visible after edge k+DB+1
        raw_in[0] = 1'b0;
        steps(DB + 1);
        check_eq("press_early", 32'(level_out[0]), 32'd0);
        step();
        check_eq("press_level", 32'(level_out[0]), 32'd1);
        check_eq("press_strobe", 32'(press_pulse), 32'b0001);
        step();
        check_eq("press_strobe_end", 32'(press_pulse), 32'b0000);

        // Bouncing channel 1: low phases shorter than DB never register
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            raw_in[1] = 1'b0; steps(3);
            raw_in[1] = 1'b1; steps(2);
        end
        check_eq("bounce_no_press", 32'(cnt_press[1]), 32'd0);
        raw_in[1] = 1'b0;
        steps(DB + 1);
        check_eq("bounce_early", 32'(cnt_press[1]), 32'd0);
        step();
        check_eq("bounce_strobe", 32'(press_pulse), 32'b0010);
        steps(10);
        check_eq("bounce_one_press", 32'(cnt_press[1]), 32'd1);

        // Short release glitch on channel 0 is rejected, a long one is not
        clear_counts();
        raw_in[0] = 1'b1; steps(2);
        raw_in[0] = 1'b0; steps(10);
        check_eq("glitch_no_release", 32'(cnt_release[0]), 32'd0);
        check_eq("glitch_level_held", 32'(level_out[0]), 32'd1);
        raw_in[0] = 1'b1; steps(6);
        raw_in[0] = 1'b0; steps(12);
        check_eq("long_release", 32'(cnt_release[0]), 32'd1);

        // Simultaneous press on channels 2 and 3
        raw_in[3:2] = 2'b00;
        steps(DB + 2);
        check_eq("simul_strobe", 32'(press_pulse), 32'b1100);
        check_eq("simul_any", 32'(any_level), 32'd1);
        raw_in = 4'b1111;
        steps(12);
        check_eq("all_released", 32'(level_out), 32'h0);

        // Long hold on channel 0 then release
        clear_counts();
        raw_in[0] = 1'b0;
        steps(DB + 2);
        check_eq("hold_press", 32'(press_pulse[0]), 32'd1);
        steps(28);
        raw_in[0] = 1'b1;
        steps(25);
`ifdef BUTTON_CONDITIONER_REPEAT_EN
        hold_pulses = 6;
`else
        hold_pulses = 1;
`endif
        check_eq("hold_pulse_count", 32'(cnt_press[0]), 32'(hold_pulses));
        check_eq("hold_release_count", 32'(cnt_release[0]), 32'd1);

        // Randomized traffic with occasional mid-activity resets
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) raw_in[c] = ~raw_in[c];
            end
            sync_reset = ($urandom_range(0, 399) == 0);
            step();
        end
        sync_reset = 1'b0;

        // Button held through reset release registers as a fresh press
        raw_in = 4'b1110;
        steps(DB + 2);
        sync_reset = 1'b1;
        step();
        check_eq("mid_hold_reset", 32'(level_out), 32'h0);
        sync_reset = 1'b0;
        clear_counts();
        steps(DB + 2);
        check_eq("held_through_reset", 32'(cnt_press[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
